vx_mem_responder: RTL and testbench
===================================

# vx_mem_responder

Memory-side responder for the cache/bypass memory request interface: accepts line-granular requests carrying per-port byte enables, word selects and data, and serves them from a local line RAM. Writes merge selected words/bytes into the addressed line. Reads return the full line with the request tag, in order, after a fixed pipeline latency. It is the terminating endpoint for the request/response channel that non-cacheable bypass and cache banks drive, used for on-chip scratch/IO windows and as a synthesizable memory stand-in.

## Interface
- NUM_PORTS, 1: word ports per memory request
- CORE_DATA_SIZE, 4: bytes per port word
- MEM_DATA_SIZE, 16: bytes per line
- MEM_ADDR_WIDTH, 26: line address width
- MEM_TAG_WIDTH, 8: request/response tag width
- RAM_DEPTH, 256: lines stored, power of two
- LATENCY, 2: read latency in cycles, at least 1
- RSP_QUEUE_SIZE, 4: response queue entries, power of two, at least 2
- Derived: CORE_DATA_WIDTH=CORE_DATA_SIZE*8, MEM_DATA_WIDTH=MEM_DATA_SIZE*8, MEM_SELECT_BITS=`UP(`CLOG2(MEM_DATA_SIZE/CORE_DATA_SIZE)), LINE_BITS=`CLOG2(RAM_DEPTH)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1=write, 0=read
- mem_req_addr  in  MEM_ADDR_WIDTH  line address
- mem_req_pmask  in  NUM_PORTS  active write ports
- mem_req_byteen  in  NUM_PORTS*CORE_DATA_SIZE  per-port byte enables
- mem_req_wsel  in  NUM_PORTS*MEM_SELECT_BITS  per-port word index within line
- mem_req_data  in  NUM_PORTS*CORE_DATA_WIDTH  per-port write data
- mem_req_tag  in  MEM_TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid&&ready
- mem_rsp_valid  out  1  read response valid
- mem_rsp_data  out  MEM_DATA_WIDTH  read line
- mem_rsp_tag  out  MEM_TAG_WIDTH  tag of originating read
- mem_rsp_ready  in  1  response consumed when valid&&ready

## Operation
- Line index = mem_req_addr[LINE_BITS-1:0]. Upper address bits are ignored, so addresses alias modulo RAM_DEPTH.
- Write: for each port p with pmask[p]=1, byte b of word wsel[p] is updated with data[p] when byteen[p][b]=1. All other bytes are unchanged. If ports overlap on a byte, the higher port index wins. A write produces no response.
- Read: captures the full line and the tag, and enqueues {data, tag} LATENCY cycles later. Responses are returned in acceptance order.
- Credits: counter initialised to RSP_QUEUE_SIZE, width `CLOG2(RSP_QUEUE_SIZE+1).
  - Decrements on each read accept.
  - Increments on each response handshake.
  - Read accept and response handshake in the same cycle leave it unchanged.
  - The counter never underflows or overflows; the bench asserts this.
- mem_req_ready = ~reset && (mem_req_rw || credits!=0).
  - Writes are never stalled.
  - Ready depends on rw, not on valid.
- mem_rsp_data and mem_rsp_tag hold stable while valid && ~ready.

## Timing
- Write accepted in cycle t is visible to a read accepted in cycle t+1 or later. Only one request is accepted per cycle, so there is no same-cycle read/write conflict.
- Read accepted in cycle t with an empty queue: mem_rsp_valid=1 in cycle t+LATENCY.
- Sustained throughput is 1 read per cycle while mem_rsp_ready=1.
- With mem_rsp_ready=0, exactly RSP_QUEUE_SIZE reads are accepted and then ready drops for reads. It rises the cycle after the first response handshake.
- Reset, any cycle:
  - Next cycle: mem_req_ready=0 while reset is high, and mem_rsp_valid=0.
  - Credits return to RSP_QUEUE_SIZE.
  - Pipeline valid bits clear and the queue empties, so in-flight reads are discarded.
  - RAM contents are retained, not cleared.
  - First accept is possible in the cycle reset is low.

## Structure
- Pipeline: a LATENCY-deep valid/tag shift stage alongside the RAM read register. The RAM is registered-output, and extra stages are flops.
- Sub-module: VX_fifo_queue (existing) for the response queue, DATAW=MEM_DATA_WIDTH+MEM_TAG_WIDTH, DEPTH=RSP_QUEUE_SIZE.
- Shared package (VX_cache_define.vh): MEM_SELECT_BITS derivation and the `UP/`CLOG2 macros, so this block matches requesters bit-for-bit. No new typedefs.

## Test plan
- Full-line write then read: write, pmask=1, wsel=0..3 sequentially to addr 0x10 with data 0x11111111..0x44444444, byteen=0xF; read addr 0x10 tag 0x5A -> rsp line 0x44444444_33333333_22222222_11111111, tag 0x5A, valid at accept+LATENCY.
- Partial bytes: write addr 0x10 wsel=2 byteen=0x3 data 0xDEADBEEF -> subsequent read word2=0x3333BEEF, other words unchanged.
- Aliasing: write addr 0x110 (RAM_DEPTH=256) -> read addr 0x10 returns the written data.
- Backpressure: mem_rsp_ready=0, issue 6 reads tags 1..6 -> only tags 1..4 accepted; ready low for reads while a write is still accepted. Release ready -> responses 1,2,3,4 in order, then 5,6 accepted.
- Streaming: 16 back-to-back reads with mem_rsp_ready=1 -> 16 consecutive valid responses, no bubbles after the first LATENCY cycles.
- Reset mid-flight: 3 reads accepted, reset asserted the next cycle -> no responses after reset, credits=RSP_QUEUE_SIZE, previously written data still readable.

Source files
------------

// File: rtl/vx_mem_responder_pkg.sv
// Shared sizing helpers for the memory request/response channel.
// Keeps select-field widths identical to the requesters.
package vx_mem_responder_pkg;

    function automatic int clog2(input int n);
        return $clog2(n);
    endfunction

    function automatic int up(input int n);
        return (n != 0) ? n : 1;
    endfunction

    function automatic int mem_select_bits(input int line_size, input int word_size);
        return up(clog2(line_size / word_size));
    endfunction

endpackage

// File: rtl/vx_mem_responder_fifo.sv
// Response queue: power-of-two circular buffer with wrap-bit pointers.
// Head entry is read straight from storage, so it holds until popped.
module vx_mem_responder_fifo
    import vx_mem_responder_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer advance; reset empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    assign data_out = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);

endmodule

// File: rtl/vx_mem_responder.sv
// Line-RAM endpoint for the memory request channel: merges writes,
// returns read lines in order after a fixed latency, credit-limited.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int NUM_PORTS      = 1,
    parameter int CORE_DATA_SIZE = 4,
    parameter int MEM_DATA_SIZE  = 16,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter int MEM_TAG_WIDTH  = 8,
    parameter int RAM_DEPTH      = 256,
    parameter int LATENCY        = 2,
    parameter int RSP_QUEUE_SIZE = 4,
    localparam int CORE_DATA_WIDTH = CORE_DATA_SIZE * 8,
    localparam int MEM_DATA_WIDTH  = MEM_DATA_SIZE * 8,
    localparam int MEM_SELECT_BITS = mem_select_bits(MEM_DATA_SIZE, CORE_DATA_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mem_req_valid,
    input  logic                                 mem_req_rw,
    input  logic [MEM_ADDR_WIDTH-1:0]            mem_req_addr,
    input  logic [NUM_PORTS-1:0]                 mem_req_pmask,
    input  logic [NUM_PORTS*CORE_DATA_SIZE-1:0]  mem_req_byteen,
    input  logic [NUM_PORTS*MEM_SELECT_BITS-1:0] mem_req_wsel,
    input  logic [NUM_PORTS*CORE_DATA_WIDTH-1:0] mem_req_data,
    input  logic [MEM_TAG_WIDTH-1:0]             mem_req_tag,
    output logic                                 mem_req_ready,
    output logic                                 mem_rsp_valid,
    output logic [MEM_DATA_WIDTH-1:0]            mem_rsp_data,
    output logic [MEM_TAG_WIDTH-1:0]             mem_rsp_tag,
    input  logic                                 mem_rsp_ready
);

    localparam int LINE_BITS = clog2(RAM_DEPTH);
    localparam int CREDIT_W  = clog2(RSP_QUEUE_SIZE + 1);
    localparam int RSP_W     = MEM_DATA_WIDTH + MEM_TAG_WIDTH;

    logic [MEM_DATA_WIDTH-1:0] ram [RAM_DEPTH];
    logic [LINE_BITS-1:0]      line_idx;
    logic                      unused_addr;
    logic                      wr_fire;
    logic                      rd_fire;
    logic                      rsp_fire;
    logic [CREDIT_W-1:0]       credits;
    logic                      push_valid;
    logic [RSP_W-1:0]          push_data;
    logic [RSP_W-1:0]          rsp_dout;
    logic                      rsp_empty;

    assign line_idx    = mem_req_addr[LINE_BITS-1:0];
    assign unused_addr = ^mem_req_addr[MEM_ADDR_WIDTH-1:LINE_BITS];

    assign mem_req_ready = ~reset && (mem_req_rw || credits != '0);
    assign wr_fire  = mem_req_valid && mem_req_ready && mem_req_rw;
    assign rd_fire  = mem_req_valid && mem_req_ready && !mem_req_rw;
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    // Byte-merge write; later ports override earlier ones on overlap
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int b = 0; b < CORE_DATA_SIZE; b++) begin
                    if (mem_req_pmask[p] && mem_req_byteen[p*CORE_DATA_SIZE + b]) begin
                        ram[line_idx][(int'(mem_req_wsel[p*MEM_SELECT_BITS +: MEM_SELECT_BITS])
                                       * CORE_DATA_SIZE + b) * 8 +: 8]
                            <= mem_req_data[(p*CORE_DATA_SIZE + b)*8 +: 8];
                    end
                end
            end
        end
    end

    if (LATENCY == 1) begin : g_direct
        assign push_valid = rd_fire;
        assign push_data  = {ram[line_idx], mem_req_tag};
    end else begin : g_pipe
        localparam int S = LATENCY - 1;

        logic [S-1:0]              pv;
        logic [MEM_DATA_WIDTH-1:0] pd [S];
        logic [MEM_TAG_WIDTH-1:0]  pt [S];

        // Valid bits of the read pipeline; cleared on reset
        always_ff @(posedge clk) begin
            if (reset) begin
                pv <= '0;
            end else begin
                pv[0] <= rd_fire;
                for (int s = 1; s < S; s++) pv[s] <= pv[s-1];
            end
        end

        // Registered RAM read followed by plain data/tag flops
        always_ff @(posedge clk) begin
            pd[0] <= ram[line_idx];
            pt[0] <= mem_req_tag;
            for (int s = 1; s < S; s++) begin
                pd[s] <= pd[s-1];
                pt[s] <= pt[s-1];
            end
        end

        assign push_valid = pv[S-1];
        assign push_data  = {pd[S-1], pt[S-1]};
    end

    // Credits bound reads in flight plus queued, so the queue never overflows
    always_ff @(posedge clk) begin
        if (reset) begin
            credits <= CREDIT_W'(RSP_QUEUE_SIZE);
        end else if (rd_fire && !rsp_fire) begin
            credits <= credits - 1'b1;
        end else if (!rd_fire && rsp_fire) begin
            credits <= credits + 1'b1;
        end
    end

    vx_mem_responder_fifo #(
        .DATAW (RSP_W),
        .DEPTH (RSP_QUEUE_SIZE)
    ) u_rsp_q (
        .clk      (clk),
        .reset    (reset),
        .push     (push_valid),
        .pop      (rsp_fire),
        .data_in  (push_data),
        .data_out (rsp_dout),
        .empty    (rsp_empty)
    );

    assign mem_rsp_valid = ~rsp_empty;
    assign mem_rsp_data  = rsp_dout[RSP_W-1 -: MEM_DATA_WIDTH];
    assign mem_rsp_tag   = rsp_dout[MEM_TAG_WIDTH-1:0];

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: merge, alias, latency,
// backpressure, streaming and mid-flight reset.
module tb_vx_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic         mem_req_rw;
    logic [25:0]  mem_req_addr;
    logic [0:0]   mem_req_pmask;
    logic [3:0]   mem_req_byteen;
    logic [1:0]   mem_req_wsel;
    logic [31:0]  mem_req_data;
    logic [7:0]   mem_req_tag;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic [7:0]   mem_rsp_tag;
    logic         mem_rsp_ready;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    localparam logic [127:0] W0 = 128'hFFFF_FFFF;
    localparam logic [127:0] ALL = {128{1'b1}};

    vx_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_pmask  (mem_req_pmask),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_wsel   (mem_req_wsel),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Credit counter must stay within 0..4
    always @(negedge clk) begin
        if (mon_en) check("credit_range", 128'(dut.credits <= 3'd4), 128'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [25:0] a, input logic [1:0] ws, input logic [3:0] be,
                      input logic [31:0] d, input logic pm);
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_addr   = a;
        mem_req_wsel   = ws;
        mem_req_byteen = be;
        mem_req_data   = d;
        mem_req_pmask  = pm;
        @(negedge clk);
        check("wr_ready", 128'(mem_req_ready), 128'd1);
        tick();
        mem_req_valid = 1'b0;
    endtask

    task automatic set_rd(input logic [25:0] a, input logic [7:0] t);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = a;
        mem_req_tag   = t;
    endtask

    task automatic rd(input logic [25:0] a, input logic [7:0] t);
        set_rd(a, t);
        @(negedge clk);
        check("rd_ready", 128'(mem_req_ready), 128'd1);
        tick();
        mem_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] t,
                            input logic [127:0] line, input logic [127:0] mask);
        bit seen;
        seen = 1'b0;
        mem_rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_rsp_valid) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            check({name, "_timeout"}, 128'd0, 128'd1);
        end else begin
            check({name, "_tag"}, 128'(mem_rsp_tag), 128'(t));
            check({name, "_data"}, mem_rsp_data & mask, line & mask);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        mem_req_valid  = 1'b1;
        mem_req_rw     = 1'b1;
        mem_req_addr   = '0;
        mem_req_pmask  = 1'b1;
        mem_req_byteen = '0;
        mem_req_wsel   = '0;
        mem_req_data   = '0;
        mem_req_tag    = '0;
        mem_rsp_ready  = 1'b1;

        @(negedge clk);
        check("rst_ready", 128'(mem_req_ready), 128'd0);
        tick();
        tick();
        @(negedge clk);
        check("rst_rsp_valid", 128'(mem_rsp_valid), 128'd0);
        check("rst_credits", 128'(dut.credits), 128'd4);
        mem_req_valid = 1'b0;
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++)
            wr(26'h10, 2'(i), 4'hF, 32'h1111_1111 * (i + 1), 1'b1);
        rd(26'h10, 8'h5A);
        @(negedge clk);
        check("lat_t1_valid", 128'(mem_rsp_valid), 128'd0);
        tick();
        @(negedge clk);
        check("lat_t2_valid", 128'(mem_rsp_valid), 128'd1);
        check("lat_t2_tag", 128'(mem_rsp_tag), 128'h5A);
        check("full_line", mem_rsp_data, 128'h44444444_33333333_22222222_11111111);
        tick();

        wr(26'h10, 2'd2, 4'h3, 32'hDEAD_BEEF, 1'b1);
        rd(26'h10, 8'h21);
        wait_rsp("partial", 8'h21, 128'h44444444_3333BEEF_22222222_11111111, ALL);

        wr(26'h110, 2'd1, 4'hF, 32'hCAFE_F00D, 1'b1);
        wr(26'h10, 2'd3, 4'hF, 32'h0000_0000, 1'b0);
        rd(26'h10, 8'h3C);
        wait_rsp("alias", 8'h3C, 128'h44444444_3333BEEF_CAFEF00D_11111111, ALL);

        for (int i = 1; i <= 6; i++)
            wr(26'h20 + 26'(i), 2'd0, 4'hF, 32'h1000 + 32'(i), 1'b1);
        mem_rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            rd(26'h20 + 26'(i), 8'(i));
        set_rd(26'h25, 8'd5);
        @(negedge clk);
        check("bp_rd5_blocked", 128'(mem_req_ready), 128'd0);
        tick();
        @(negedge clk);
        check("bp_rd5_blocked2", 128'(mem_req_ready), 128'd0);
        tick();
        wr(26'h30, 2'd0, 4'hF, 32'h5555_AAAA, 1'b1);
        set_rd(26'h25, 8'd5);
        @(negedge clk);
        check("bp_rd5_blocked3", 128'(mem_req_ready), 128'd0);
        check("bp_hold_tag", 128'(mem_rsp_tag), 128'd1);
        check("bp_hold_data", mem_rsp_data & W0, 128'h1001);
        tick();
        @(negedge clk);
        check("bp_hold_tag2", 128'(mem_rsp_tag), 128'd1);
        tick();
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_first_hs_valid", 128'(mem_rsp_valid), 128'd1);
        check("bp_first_hs_tag", 128'(mem_rsp_tag), 128'd1);
        check("bp_first_hs_ready", 128'(mem_req_ready), 128'd0);
        tick();
        @(negedge clk);
        check("bp_ready_rise", 128'(mem_req_ready), 128'd1);
        check("bp_tag2", 128'(mem_rsp_tag), 128'd2);
        check("bp_data2", mem_rsp_data & W0, 128'h1002);
        tick();
        set_rd(26'h26, 8'd6);
        @(negedge clk);
        check("bp_rd6_ready", 128'(mem_req_ready), 128'd1);
        check("bp_tag3", 128'(mem_rsp_tag), 128'd3);
        tick();
        mem_req_valid = 1'b0;
        wait_rsp("bp4", 8'd4, 128'h1004, W0);
        wait_rsp("bp5", 8'd5, 128'h1005, W0);
        wait_rsp("bp6", 8'd6, 128'h1006, W0);

        mem_rsp_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) set_rd(26'h10, 8'h80 + 8'(k));
            else mem_req_valid = 1'b0;
            @(negedge clk);
            if (k < 16) check("stream_ready", 128'(mem_req_ready), 128'd1);
            if (k < 2) begin
                check("stream_lead", 128'(mem_rsp_valid), 128'd0);
            end else begin
                check("stream_valid", 128'(mem_rsp_valid), 128'd1);
                check("stream_tag", 128'(mem_rsp_tag), 128'h80 + 128'(k - 2));
            end
            tick();
        end

        mem_rsp_ready = 1'b0;
        rd(26'h10, 8'h61);
        rd(26'h10, 8'h62);
        rd(26'h10, 8'h63);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 128'(mem_req_ready), 128'd0);
        tick();
        @(negedge clk);
        check("mid_rst_valid", 128'(mem_rsp_valid), 128'd0);
        check("mid_rst_credits", 128'(dut.credits), 128'd4);
        tick();
        reset = 1'b0;
        mem_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", 128'(mem_rsp_valid), 128'd0);
            tick();
        end
        rd(26'h10, 8'h77);
        wait_rsp("retained", 8'h77, 128'h44444444_3333BEEF_CAFEF00D_11111111, ALL);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
